// File: rtl/axi_slv_ctrl_wr_if.sv
// AXI4 slave write-side bus bundle (AW, W, B channels) for axi_slv_ctrl_wr.
// Width macros default here when no shared AXI definitions file is present.
`ifndef AXI_ID_WIDTH
  `define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
  `define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
  `define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
  `define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
  `define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
  `define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_LOCK_WIDTH
  `define AXI_LOCK_WIDTH 1
`endif
`ifndef AXI_CACHE_WIDTH
  `define AXI_CACHE_WIDTH 4
`endif
`ifndef AXI_PROT_WIDTH
  `define AXI_PROT_WIDTH 3
`endif
`ifndef AXI_QOS_WIDTH
  `define AXI_QOS_WIDTH 4
`endif
`ifndef AXI_REGION_WIDTH
  `define AXI_REGION_WIDTH 4
`endif
`ifndef AXI_RESP_WIDTH
  `define AXI_RESP_WIDTH 2
`endif

interface axi_slv_ctrl_wr_if;
  logic [`AXI_ID_WIDTH-1:0]       axi_slv_awid;
  logic [`AXI_ADDR_WIDTH-1:0]     axi_slv_awaddr;
  logic [`AXI_LEN_WIDTH-1:0]      axi_slv_awlen;
  logic [`AXI_SIZE_WIDTH-1:0]     axi_slv_awsize;
  logic [`AXI_BURST_WIDTH-1:0]    axi_slv_awburst;
  logic [`AXI_LOCK_WIDTH-1:0]     axi_slv_awlock;
  logic [`AXI_CACHE_WIDTH-1:0]    axi_slv_awcache;
  logic [`AXI_PROT_WIDTH-1:0]     axi_slv_awprot;
  logic [`AXI_QOS_WIDTH-1:0]      axi_slv_awqos;
  logic [`AXI_REGION_WIDTH-1:0]   axi_slv_awregion;
  logic                           axi_slv_awvalid;
  logic                           axi_slv_awready;

  logic [`AXI_DATA_WIDTH-1:0]     axi_slv_wdata;
  logic [`AXI_DATA_WIDTH/8-1:0]   axi_slv_wstrb;
  logic                           axi_slv_wlast;
  logic                           axi_slv_wvalid;
  logic                           axi_slv_wready;

  logic [`AXI_ID_WIDTH-1:0]       axi_slv_bid;
  logic [`AXI_RESP_WIDTH-1:0]     axi_slv_bresp;
  logic                           axi_slv_bvalid;
  logic                           axi_slv_bready;

  modport master (
    output axi_slv_awid, axi_slv_awaddr, axi_slv_awlen, axi_slv_awsize, axi_slv_awburst,
           axi_slv_awlock, axi_slv_awcache, axi_slv_awprot, axi_slv_awqos, axi_slv_awregion,
           axi_slv_awvalid, axi_slv_wdata, axi_slv_wstrb, axi_slv_wlast, axi_slv_wvalid,
           axi_slv_bready,
    input  axi_slv_awready, axi_slv_wready, axi_slv_bid, axi_slv_bresp, axi_slv_bvalid
  );

  modport slave (
    input  axi_slv_awid, axi_slv_awaddr, axi_slv_awlen, axi_slv_awsize, axi_slv_awburst,
           axi_slv_awlock, axi_slv_awcache, axi_slv_awprot, axi_slv_awqos, axi_slv_awregion,
           axi_slv_awvalid, axi_slv_wdata, axi_slv_wstrb, axi_slv_wlast, axi_slv_wvalid,
           axi_slv_bready,
    output axi_slv_awready, axi_slv_wready, axi_slv_bid, axi_slv_bresp, axi_slv_bvalid
  );
endinterface

// File: rtl/axi_slv_ctrl_wr.sv
// AXI4 slave write controller: one burst at a time, per-beat memory write strobe, single B.
// Define AXI_SLV_WR_WRAP_EN to support WRAP bursts; otherwise WRAP completes with SLVERR.
`ifndef AXI_ID_WIDTH
  `define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
  `define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
  `define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
  `define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
  `define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
  `define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_RESP_WIDTH
  `define AXI_RESP_WIDTH 2
`endif

module axi_slv_ctrl_wr #(
  parameter int ADDR_LSB = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  axi_slv_ctrl_wr_if.slave             axi,
  output logic                         wr_req_en,
  output logic [`AXI_ADDR_WIDTH-1:0]   wr_addr,
  output logic [`AXI_DATA_WIDTH-1:0]   wr_data,
  output logic [`AXI_DATA_WIDTH/8-1:0] wr_strb
);
  localparam int ID_W     = `AXI_ID_WIDTH;
  localparam int ADDR_W   = `AXI_ADDR_WIDTH;
  localparam int DATA_W   = `AXI_DATA_WIDTH;
  localparam int LEN_W    = `AXI_LEN_WIDTH;
  localparam int SIZE_W   = `AXI_SIZE_WIDTH;
  localparam int BURST_W  = `AXI_BURST_WIDTH;
  localparam int RESP_W   = `AXI_RESP_WIDTH;
  localparam int STRB_W   = DATA_W / 8;
  localparam int MAX_SIZE = $clog2(STRB_W);

  localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;
  localparam logic [RESP_W-1:0]  RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_RESP} state_e;

  state_e              state_q, state_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [ID_W-1:0]     bid_q, bid_d;
  logic [RESP_W-1:0]   bresp_q, bresp_d;
  logic                wr_req_en_q, wr_req_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [STRB_W-1:0]   wr_strb_q, wr_strb_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                aw_err_q, aw_err_d;   // burst-level error: beats are swallowed, not written
  logic                err_q, err_d;         // any error, reported in B

  logic              aw_hs, w_hs, b_hs;
  logic              aw_err, last_beat, wlast_err;
  logic [ADDR_W-1:0] beat_bytes, next_addr;

  assign aw_hs     = axi.axi_slv_awvalid & awready_q;
  assign w_hs      = axi.axi_slv_wvalid & wready_q;
  assign b_hs      = bvalid_q & axi.axi_slv_bready;
  assign last_beat = (cnt_q == len_q);
  assign wlast_err = (axi.axi_slv_wlast != last_beat);

  always_comb begin
    aw_err = (axi.axi_slv_awburst == 2'b11) ||
             (axi.axi_slv_awsize > SIZE_W'(MAX_SIZE));
`ifdef AXI_SLV_WR_WRAP_EN
    if (axi.axi_slv_awburst == BURST_WRAP && !(axi.axi_slv_awlen inside {8'd1, 8'd3, 8'd7, 8'd15}))
      aw_err = 1'b1;
`else
    if (axi.axi_slv_awburst == BURST_WRAP)
      aw_err = 1'b1;
`endif
  end

`ifdef AXI_SLV_WR_WRAP_EN
  logic [ADDR_W-1:0] wrap_win;
  assign wrap_win = (ADDR_W'(len_q) + ADDR_W'(1)) << size_q;
`endif

  // Address of the following beat, derived from the current beat address.
  always_comb begin
    beat_bytes = ADDR_W'(1) << size_q;
    next_addr  = addr_q;
    case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_INCR:  next_addr = (addr_q & ~(beat_bytes - ADDR_W'(1))) + beat_bytes;
`ifdef AXI_SLV_WR_WRAP_EN
      BURST_WRAP:  next_addr = (addr_q & ~(wrap_win - ADDR_W'(1))) |
                               ((addr_q + beat_bytes) & (wrap_win - ADDR_W'(1)));
`endif
      default:     next_addr = addr_q;
    endcase
  end

  always_comb begin
    // NOTE: every _d signal takes a default first so no path through the case infers a latch.
    state_d     = state_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    wr_req_en_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_strb_d   = wr_strb_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    cnt_d       = cnt_q;
    aw_err_d    = aw_err_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        awready_d = 1'b1;
        if (aw_hs) begin
          state_d   = ST_DATA;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          id_d      = axi.axi_slv_awid;
          addr_d    = axi.axi_slv_awaddr;
          len_d     = axi.axi_slv_awlen;
          size_d    = axi.axi_slv_awsize;
          burst_d   = axi.axi_slv_awburst;
          cnt_d     = '0;
          aw_err_d  = aw_err;
          err_d     = aw_err;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          if (!aw_err_q) begin
            wr_req_en_d = 1'b1;
            wr_addr_d   = addr_q;
            wr_data_d   = axi.axi_slv_wdata;
            wr_strb_d   = axi.axi_slv_wstrb;
          end
          addr_d = next_addr;
          cnt_d  = cnt_q + LEN_W'(1);
          err_d  = err_q | wlast_err;
          if (last_beat) begin
            state_d  = ST_RESP;
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = id_q;
            bresp_d  = (err_q | wlast_err) ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      ST_RESP: begin
        if (b_hs) begin
          state_d   = ST_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= ST_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= '0;
      wr_req_en_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_strb_q   <= '0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      cnt_q       <= '0;
      aw_err_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      wr_req_en_q <= wr_req_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_strb_q   <= wr_strb_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      cnt_q       <= cnt_d;
      aw_err_q    <= aw_err_d;
      err_q       <= err_d;
    end
  end

  assign axi.axi_slv_awready = awready_q;
  assign axi.axi_slv_wready  = wready_q;
  assign axi.axi_slv_bvalid  = bvalid_q;
  assign axi.axi_slv_bid     = bid_q;
  assign axi.axi_slv_bresp   = bresp_q;
  assign wr_req_en           = wr_req_en_q;
  assign wr_addr             = wr_addr_q;
  assign wr_data             = wr_data_q;
  assign wr_strb             = wr_strb_q;

  // Attributes the memory has no use for; ADDR_LSB is descriptive only.
  logic unused_ok;
  assign unused_ok = ^{axi.axi_slv_awlock, axi.axi_slv_awcache, axi.axi_slv_awprot,
                       axi.axi_slv_awqos, axi.axi_slv_awregion, 1'(ADDR_LSB)};
endmodule

// File: tb/tb_axi_slv_ctrl_wr.sv
// Directed bench for axi_slv_ctrl_wr: table of bursts plus hand-timed corner sequences.
module tb_axi_slv_ctrl_wr;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  axi_slv_ctrl_wr_if bus ();

  axi_slv_ctrl_wr dut (
    .clk       (clk),
    .rst       (rst),
    .axi       (bus),
    .wr_req_en (wr_req_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrs   = 0;

  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [3:0]  got_strb[$];

  always @(negedge clk) begin
    if (wr_req_en === 1'b1) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
      got_strb.push_back(wr_strb);
    end
  end

  typedef struct {
    logic [3:0]        id;
    logic [31:0]       addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    int                last_mode;  // 0 proper wlast, 1 extra wlast on beat 1, 2 no wlast
    int                exp_n;
    logic [3:0][31:0]  exp_addr;
    logic [1:0]        exp_resp;
  } vec_t;

  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input int mode,
                              input int n, input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3, input logic [1:0] resp);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.last_mode = mode; v.exp_n = n; v.exp_resp = resp;
    v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_addr[2] = a2; v.exp_addr[3] = a3;
    return v;
  endfunction

  function automatic logic [31:0] dat(input int i, input int b);
    return {8'hA5, 8'(i), 8'(b), 8'h5A};
  endfunction

  function automatic logic [3:0] strb_of(input int b);
    return 4'hF >> b;
  endfunction

  task automatic idle_inputs();
    bus.axi_slv_awid = '0; bus.axi_slv_awaddr = '0; bus.axi_slv_awlen = '0;
    bus.axi_slv_awsize = '0; bus.axi_slv_awburst = '0; bus.axi_slv_awlock = '0;
    bus.axi_slv_awcache = '0; bus.axi_slv_awprot = '0; bus.axi_slv_awqos = '0;
    bus.axi_slv_awregion = '0; bus.axi_slv_awvalid = 1'b0;
    bus.axi_slv_wdata = '0; bus.axi_slv_wstrb = '0; bus.axi_slv_wlast = 1'b0;
    bus.axi_slv_wvalid = 1'b0; bus.axi_slv_bready = 1'b0;
  endtask

  task automatic set_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    bus.axi_slv_awid = id; bus.axi_slv_awaddr = addr; bus.axi_slv_awlen = len;
    bus.axi_slv_awsize = size; bus.axi_slv_awburst = burst;
    bus.axi_slv_awcache = 4'h3; bus.axi_slv_awprot = 3'h2;
    bus.axi_slv_awvalid = 1'b1;
  endtask

  // Complete one burst and compare the writes it produced against the vector.
  task automatic run_txn(input int i, input vec_t v);
    bit ok;
    int nb;
    got_addr.delete(); got_data.delete(); got_strb.delete();
    set_aw(v.id, v.addr, v.len, v.size, v.burst);
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      if (bus.axi_slv_awready) begin ok = 1; step(); break; end
      step();
    end
    if (!ok) check($sformatf("v%0d aw_wait", i), {31'd0, bus.axi_slv_awready}, 32'd1);
    bus.axi_slv_awvalid = 1'b0;
    nb = int'(v.len) + 1;
    for (int b = 0; b < nb; b++) begin
      bus.axi_slv_wvalid = 1'b1;
      bus.axi_slv_wdata  = dat(i, b);
      bus.axi_slv_wstrb  = strb_of(b);
      case (v.last_mode)
        1:       bus.axi_slv_wlast = (b == 1) || (b == nb - 1);
        2:       bus.axi_slv_wlast = 1'b0;
        default: bus.axi_slv_wlast = (b == nb - 1);
      endcase
      ok = 0;
      for (int c = 0; c < 50; c++) begin
        if (bus.axi_slv_wready) begin ok = 1; step(); break; end
        step();
      end
      if (!ok) check($sformatf("v%0d w_wait beat%0d", i, b), {31'd0, bus.axi_slv_wready}, 32'd1);
    end
    bus.axi_slv_wvalid = 1'b0;
    bus.axi_slv_wlast  = 1'b0;
    bus.axi_slv_bready = 1'b1;
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      if (bus.axi_slv_bvalid) begin
        ok = 1;
        check($sformatf("v%0d bid", i), {28'd0, bus.axi_slv_bid}, {28'd0, v.id});
        check($sformatf("v%0d bresp", i), {30'd0, bus.axi_slv_bresp}, {30'd0, v.exp_resp});
        step();
        break;
      end
      step();
    end
    if (!ok) check($sformatf("v%0d b_wait", i), {31'd0, bus.axi_slv_bvalid}, 32'd1);
    bus.axi_slv_bready = 1'b0;
    check($sformatf("v%0d awready_after_b", i), {31'd0, bus.axi_slv_awready}, 32'd1);
    check($sformatf("v%0d write_count", i), got_addr.size(), v.exp_n);
    for (int b = 0; b < v.exp_n && b < got_addr.size(); b++) begin
      check($sformatf("v%0d wr_addr beat%0d", i, b), got_addr[b], v.exp_addr[b]);
      check($sformatf("v%0d wr_data beat%0d", i, b), got_data[b], dat(i, b));
      check($sformatf("v%0d wr_strb beat%0d", i, b), {28'd0, got_strb[b]}, {28'd0, strb_of(b)});
    end
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = mk(4'h5, 32'h100, 8'd3, 3'd2, 2'b01, 0, 4, 32'h100, 32'h104, 32'h108, 32'h10C, OKAY);
`ifdef AXI_SLV_WR_WRAP_EN
    vecs[1]  = mk(4'h6, 32'h108, 8'd3, 3'd2, 2'b10, 0, 4, 32'h108, 32'h10C, 32'h100, 32'h104, OKAY);
    vecs[10] = mk(4'hF, 32'h03C, 8'd1, 3'd2, 2'b10, 0, 2, 32'h03C, 32'h038, 0, 0, OKAY);
`else
    vecs[1]  = mk(4'h6, 32'h108, 8'd3, 3'd2, 2'b10, 0, 0, 0, 0, 0, 0, SLVERR);
    vecs[10] = mk(4'hF, 32'h03C, 8'd1, 3'd2, 2'b10, 0, 0, 0, 0, 0, 0, SLVERR);
`endif
    vecs[2]  = mk(4'h7, 32'h200, 8'd3, 3'd2, 2'b01, 1, 4, 32'h200, 32'h204, 32'h208, 32'h20C, SLVERR);
    vecs[3]  = mk(4'h8, 32'h300, 8'd1, 3'd2, 2'b11, 0, 0, 0, 0, 0, 0, SLVERR);
    vecs[4]  = mk(4'h9, 32'h400, 8'd1, 3'd3, 2'b01, 0, 0, 0, 0, 0, 0, SLVERR);
    vecs[5]  = mk(4'hA, 32'h500, 8'd2, 3'd2, 2'b00, 0, 3, 32'h500, 32'h500, 32'h500, 0, OKAY);
    vecs[6]  = mk(4'hB, 32'h041, 8'd1, 3'd2, 2'b01, 0, 2, 32'h041, 32'h044, 0, 0, OKAY);
    vecs[7]  = mk(4'hC, 32'h600, 8'd1, 3'd2, 2'b01, 2, 2, 32'h600, 32'h604, 0, 0, SLVERR);
    vecs[8]  = mk(4'hD, 32'h007, 8'd2, 3'd0, 2'b01, 0, 3, 32'h007, 32'h008, 32'h009, 0, OKAY);
    vecs[9]  = mk(4'hE, 32'h700, 8'd2, 3'd2, 2'b10, 0, 0, 0, 0, 0, 0, SLVERR);

    idle_inputs();
    rst = 1'b1;
    repeat (3) step();
    check("rst awready", {31'd0, bus.axi_slv_awready}, 32'd0);
    check("rst wready", {31'd0, bus.axi_slv_wready}, 32'd0);
    check("rst bvalid", {31'd0, bus.axi_slv_bvalid}, 32'd0);
    check("rst wr_req_en", {31'd0, wr_req_en}, 32'd0);
    check("rst bid", {28'd0, bus.axi_slv_bid}, 32'd0);
    check("rst bresp", {30'd0, bus.axi_slv_bresp}, 32'd0);
    check("rst wr_addr", wr_addr, 32'd0);
    check("rst wr_data", wr_data, 32'd0);
    check("rst wr_strb", {28'd0, wr_strb}, 32'd0);
    rst = 1'b0;
    step();
    check("awready after rst", {31'd0, bus.axi_slv_awready}, 32'd1);

    // Single beat, cycle-exact; W is presented early and must not be taken before AW.
    bus.axi_slv_wvalid = 1'b1; bus.axi_slv_wdata = 32'hDEADBEEF;
    bus.axi_slv_wstrb = 4'hF; bus.axi_slv_wlast = 1'b1;
    step();
    check("early W wready", {31'd0, bus.axi_slv_wready}, 32'd0);
    check("early W no write", {31'd0, wr_req_en}, 32'd0);
    set_aw(4'h3, 32'h40, 8'd0, 3'd2, 2'b01);
    step();
    check("sb awready low", {31'd0, bus.axi_slv_awready}, 32'd0);
    check("sb wready", {31'd0, bus.axi_slv_wready}, 32'd1);
    check("sb no write with AW", {31'd0, wr_req_en}, 32'd0);
    bus.axi_slv_awvalid = 1'b0;
    bus.axi_slv_bready = 1'b1;
    step();
    check("sb wr_req_en", {31'd0, wr_req_en}, 32'd1);
    check("sb wr_addr", wr_addr, 32'h40);
    check("sb wr_data", wr_data, 32'hDEADBEEF);
    check("sb wr_strb", {28'd0, wr_strb}, 32'hF);
    check("sb bvalid", {31'd0, bus.axi_slv_bvalid}, 32'd1);
    check("sb bid", {28'd0, bus.axi_slv_bid}, 32'd3);
    check("sb bresp", {30'd0, bus.axi_slv_bresp}, 32'd0);
    check("sb wready low", {31'd0, bus.axi_slv_wready}, 32'd0);
    bus.axi_slv_wvalid = 1'b0; bus.axi_slv_wlast = 1'b0;
    step();
    check("sb bvalid done", {31'd0, bus.axi_slv_bvalid}, 32'd0);
    check("sb wr_req_en one cycle", {31'd0, wr_req_en}, 32'd0);
    check("sb awready again", {31'd0, bus.axi_slv_awready}, 32'd1);
    bus.axi_slv_bready = 1'b0;

    for (int i = 0; i < 11; i++) run_txn(i, vecs[i]);

    // B back-pressure with a second AW waiting.
    set_aw(4'h2, 32'h80, 8'd0, 3'd2, 2'b01);
    step();
    bus.axi_slv_awvalid = 1'b0;
    bus.axi_slv_wvalid = 1'b1; bus.axi_slv_wdata = 32'h1234_5678;
    bus.axi_slv_wstrb = 4'hF; bus.axi_slv_wlast = 1'b1;
    step();
    bus.axi_slv_wvalid = 1'b0; bus.axi_slv_wlast = 1'b0;
    set_aw(4'h9, 32'h90, 8'd0, 3'd2, 2'b01);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp bvalid c%0d", c), {31'd0, bus.axi_slv_bvalid}, 32'd1);
      check($sformatf("bp bid c%0d", c), {28'd0, bus.axi_slv_bid}, 32'd2);
      check($sformatf("bp bresp c%0d", c), {30'd0, bus.axi_slv_bresp}, 32'd0);
      check($sformatf("bp awready c%0d", c), {31'd0, bus.axi_slv_awready}, 32'd0);
      step();
    end
    bus.axi_slv_bready = 1'b1;
    step();
    bus.axi_slv_bready = 1'b0;
    check("bp bvalid cleared", {31'd0, bus.axi_slv_bvalid}, 32'd0);
    check("bp awready after B", {31'd0, bus.axi_slv_awready}, 32'd1);
    check("bp second AW not yet taken", {31'd0, bus.axi_slv_wready}, 32'd0);
    step();
    check("bp second AW taken", {31'd0, bus.axi_slv_wready}, 32'd1);
    bus.axi_slv_awvalid = 1'b0;
    bus.axi_slv_wvalid = 1'b1; bus.axi_slv_wdata = 32'h0BAD_F00D; bus.axi_slv_wlast = 1'b1;
    bus.axi_slv_bready = 1'b1;
    step();
    check("bp2 wr_addr", wr_addr, 32'h90);
    check("bp2 bid", {28'd0, bus.axi_slv_bid}, 32'd9);
    bus.axi_slv_wvalid = 1'b0; bus.axi_slv_wlast = 1'b0;
    step();
    bus.axi_slv_bready = 1'b0;

    // Reset in the middle of a burst, then a fresh single-beat write.
    got_addr.delete(); got_data.delete(); got_strb.delete();
    set_aw(4'h1, 32'hA00, 8'd3, 3'd2, 2'b01);
    step();
    bus.axi_slv_awvalid = 1'b0;
    bus.axi_slv_wvalid = 1'b1; bus.axi_slv_wdata = 32'h5555_0000; bus.axi_slv_wstrb = 4'hF;
    step();
    step();
    rst = 1'b1;
    bus.axi_slv_wvalid = 1'b0;
    step();
    check("mid rst wr_req_en", {31'd0, wr_req_en}, 32'd0);
    check("mid rst bvalid", {31'd0, bus.axi_slv_bvalid}, 32'd0);
    check("mid rst wready", {31'd0, bus.axi_slv_wready}, 32'd0);
    check("mid rst awready", {31'd0, bus.axi_slv_awready}, 32'd0);
    check("mid rst writes before abort", got_addr.size(), 2);
    step();
    rst = 1'b0;
    step();
    check("post rst awready", {31'd0, bus.axi_slv_awready}, 32'd1);
    check("post rst no B", {31'd0, bus.axi_slv_bvalid}, 32'd0);
    run_txn(20, mk(4'h4, 32'hB00, 8'd0, 3'd2, 2'b01, 0, 1, 32'hB00, 0, 0, 0, OKAY));

    $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
